// File: rtl/mem_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, exception codes,
// reorder-buffer slot layout and the unit's FSM states.
package mem_unit_pkg;

  localparam int unsigned NAlu      = 2;
  localparam int unsigned UnitWidth = 3;
  localparam int unsigned RegWidth  = 5;
  localparam int unsigned CntWidth  = 4;
  localparam int unsigned XlenWidth = 32;
  localparam int unsigned ExcpWidth = 2;

  // Slot layout, LSB first: cnt, pc, result, rd, excp.
  localparam int unsigned RobOffsetCnt    = 0;
  localparam int unsigned RobOffsetPc     = RobOffsetCnt + CntWidth;
  localparam int unsigned RobOffsetResult = RobOffsetPc + XlenWidth;
  localparam int unsigned RobOffsetRd     = RobOffsetResult + XlenWidth;
  localparam int unsigned RobOffsetExcp   = RobOffsetRd + RegWidth;
  localparam int unsigned RobWidth        = RobOffsetExcp + ExcpWidth;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLh  = 3'd1,
    OpLw  = 3'd2,
    OpSb  = 3'd3,
    OpLbu = 3'd4,
    OpLhu = 3'd5,
    OpSh  = 3'd6,
    OpSw  = 3'd7
  } mem_op_e;

  typedef enum logic [ExcpWidth-1:0] {
    NoExcp   = 2'd0,
    JExcp    = 2'd1,
    MisLoad  = 2'd2,
    MisStore = 2'd3
  } excp_e;

  // Field order matches the RobOffset* constants (first field is the MSB).
  typedef struct packed {
    excp_e                 excp;
    logic [RegWidth-1:0]   rd;
    logic [XlenWidth-1:0]  result;
    logic [XlenWidth-1:0]  pc;
    logic [CntWidth-1:0]   cnt;
  } rob_slot_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

endpackage

// File: rtl/mem_unit_lane_align.sv
// Combinational lane steering for the load/store unit.
//   op, ea_lo   : memory op and low effective-address bits
//   sdata       : store data, replicated across the lanes it may occupy
//   rdata       : memory read word, byte/half extracted and extended
//   wdata, be   : store data and byte enables for the request
//   load_data   : extended load result
//   misaligned  : op size not naturally aligned at ea_lo
module mem_lane_align
  import mem_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        zero_ext;

  assign byte_sel = rdata[{ea_lo, 3'b000} +: 8];
  assign half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];
  assign zero_ext = (op == OpLbu) || (op == OpLhu);

  // Size-dependent lane generation and load extension.
  always_comb begin
    wdata      = '0;
    be         = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (op)
      OpLb, OpLbu, OpSb: begin
        be        = 4'b0001 << ea_lo;
        wdata     = {4{sdata[7:0]}};
        load_data = zero_ext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      OpLh, OpLhu, OpSh: begin
        misaligned = ea_lo[0];
        be         = ea_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{sdata[15:0]}};
        load_data  = zero_ext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        misaligned = |ea_lo;
        be         = 4'b1111;
        wdata      = sdata;
        load_data  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Load/store execution unit: takes one issued memory op, runs a req/ack
// transaction on the data-memory port and holds a tagged reorder-buffer slot
// until the commit side frees the unit.
//   clk, rst                 : clock, synchronous active-high reset
//   i_issue_*/i_op..i_pc     : issue interface (accepted only when idle)
//   o_busy                   : unit holds an op (decoded from state)
//   o_mem_* / i_mem_*        : data-memory request/acknowledge port
//   i_free                   : commit-side free id
//   o_rob_slot               : packed {excp, rd, result, pc, cnt}; cnt 0 = empty
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int unsigned UNIT_ID = NAlu + 1,
  parameter int unsigned CNT_W   = CntWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_issue_valid,
  input  logic [UnitWidth-1:0] i_issue_unit,
  input  logic [2:0]           i_op,
  input  logic [31:0]          i_base,
  input  logic [31:0]          i_imm,
  input  logic [31:0]          i_sdata,
  input  logic [RegWidth-1:0]  i_rd,
  input  logic [CNT_W-1:0]     i_cnt,
  input  logic [31:0]          i_pc,
  output logic                 o_busy,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [31:0]          o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  output logic [3:0]           o_mem_be,
  input  logic                 i_mem_ack,
  input  logic [31:0]          i_mem_rdata,
  input  logic [UnitWidth-1:0] i_free,
  output logic [RobWidth-1:0]  o_rob_slot
);

  state_e              state;
  mem_op_e             op_q;
  logic [1:0]          ea_lo_q;
  logic [RegWidth-1:0] rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         pc_q;
  rob_slot_t           slot;

  mem_op_e     issue_op;
  logic [31:0] ea;
  logic        accept;
  logic        issue_store;
  mem_op_e     lane_op;
  logic [1:0]  lane_ea_lo;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [31:0] lane_load;
  logic        lane_misaligned;

  assign issue_op    = mem_op_e'(i_op);
  assign ea          = i_base + i_imm;
  assign accept      = (state == StIdle) && i_issue_valid
                       && (i_issue_unit == UnitWidth'(UNIT_ID));
  assign issue_store = is_store(issue_op);

  // One aligner serves both phases: the issuing op while idle, the latched op
  // while the request is outstanding.
  assign lane_op    = (state == StIdle) ? issue_op : op_q;
  assign lane_ea_lo = (state == StIdle) ? ea[1:0] : ea_lo_q;

  mem_lane_align u_align (
    .op         (lane_op),
    .ea_lo      (lane_ea_lo),
    .sdata      (i_sdata),
    .rdata      (i_mem_rdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .load_data  (lane_load),
    .misaligned (lane_misaligned)
  );

  assign o_busy     = (state != StIdle);
  assign o_rob_slot = slot;

  // Unit FSM with registered memory-port and slot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      op_q        <= OpLb;
      ea_lo_q     <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pc_q        <= '0;
      slot        <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            op_q    <= issue_op;
            ea_lo_q <= ea[1:0];
            rd_q    <= issue_store ? '0 : i_rd;
            cnt_q   <= i_cnt;
            pc_q    <= i_pc;
            if (lane_misaligned) begin
              // Memory is never touched; the slot reports the fault at once.
              slot.excp   <= issue_store ? MisStore : MisLoad;
              slot.rd     <= issue_store ? '0 : i_rd;
              slot.result <= '0;
              slot.pc     <= i_pc;
              slot.cnt    <= CntWidth'(i_cnt);
              state       <= StDone;
            end else begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= issue_store;
              o_mem_addr  <= {ea[31:2], 2'b00};
              o_mem_wdata <= issue_store ? lane_wdata : '0;
              o_mem_be    <= lane_be;
              state       <= StReq;
            end
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            o_mem_req   <= 1'b0;
            slot.excp   <= NoExcp;
            slot.rd     <= rd_q;
            slot.result <= is_store(op_q) ? '0 : lane_load;
            slot.pc     <= pc_q;
            slot.cnt    <= CntWidth'(cnt_q);
            state       <= StDone;
          end
        end
        StDone: begin
          if (i_free == UnitWidth'(UNIT_ID)) begin
            slot.cnt <= '0;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
